// File: rtl/regfile_access_ctrl_if.sv
// Bundle between decode/writeback/register-file and the access controller.
// Carries the operand-fetch channel, the writeback channel and the register-file ports.
interface regfile_access_ctrl_if #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 5,
   parameter int WBQ_DEPTH = 4
);
   localparam int CNT_W = $clog2(WBQ_DEPTH) + 1;

   // op_* and wb_* are valid/ready channels: a transfer happens on a rising edge
   // where both valid and ready are high. ready never depends on valid.
   logic                op_valid;
   logic                op_ready;
   logic [ADDR_W-1:0]   op_rs;
   logic [ADDR_W-1:0]   op_rt;

   logic                opd_valid;
   logic [DATA_W-1:0]   opd_a;
   logic [DATA_W-1:0]   opd_b;

   logic                wb_valid;
   logic                wb_ready;
   logic [ADDR_W-1:0]   wb_addr;
   logic [DATA_W-1:0]   wb_data;

   logic [ADDR_W-1:0]   rf_rd_addr1;
   logic [ADDR_W-1:0]   rf_rd_addr2;
   logic [DATA_W-1:0]   rf_rd_data1;
   logic [DATA_W-1:0]   rf_rd_data2;
   logic [ADDR_W-1:0]   rf_wr_addr;
   logic [DATA_W-1:0]   rf_wr_data;

   logic [CNT_W-1:0]    wbq_count;

   modport slave (
      input  op_valid, op_rs, op_rt,
      input  wb_valid, wb_addr, wb_data,
      input  rf_rd_data1, rf_rd_data2,
      output op_ready, opd_valid, opd_a, opd_b,
      output wb_ready, rf_rd_addr1, rf_rd_addr2,
      output rf_wr_addr, rf_wr_data, wbq_count
   );

   modport master (
      output op_valid, op_rs, op_rt,
      output wb_valid, wb_addr, wb_data,
      output rf_rd_data1, rf_rd_data2,
      input  op_ready, opd_valid, opd_a, opd_b,
      input  wb_ready, rf_rd_addr1, rf_rd_addr2,
      input  rf_wr_addr, rf_wr_data, wbq_count
   );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: 3-cycle operand fetch with forwarding from a
// writeback FIFO that drains onto the single write port whenever no read is in flight.
module regfile_access_ctrl #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 5,
   parameter int WBQ_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   regfile_access_ctrl_if.slave  bus,
   output logic [1:0]            dbgState
);
   localparam int PTR_W = $clog2(WBQ_DEPTH);
   localparam int CNT_W = $clog2(WBQ_DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } stateT;

   stateT               state;
   logic [ADDR_W-1:0]   rsReg;
   logic [ADDR_W-1:0]   rtReg;
   logic                opdValid;
   logic [DATA_W-1:0]   opdA;
   logic [DATA_W-1:0]   opdB;

   logic [ADDR_W-1:0]   qAddr [WBQ_DEPTH];
   logic [DATA_W-1:0]   qData [WBQ_DEPTH];
   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [CNT_W-1:0]    count;
   logic [DATA_W-1:0]   wrDataHold;

   logic                opReady;
   logic                wbReady;
   logic                push;
   logic                pop;
   logic [PTR_W-1:0]    fwdIdx;
   logic [DATA_W-1:0]   fwdA;
   logic [DATA_W-1:0]   fwdB;

   assign opReady = !rst && (state == IDLE);
   assign wbReady = !rst && (count != CNT_W'(WBQ_DEPTH));
   // Writes to R0 complete the handshake but never occupy a queue slot.
   assign push    = bus.wb_valid && wbReady && (bus.wb_addr != '0);
   assign pop     = !rst && (state != READ) && (count != '0);

   // Youngest match wins: queue scanned oldest to youngest, then the same-cycle push.
   always_comb begin
      fwdIdx = '0;
      fwdA   = bus.rf_rd_data1;
      fwdB   = bus.rf_rd_data2;
      for (int i = 0; i < WBQ_DEPTH; i++) begin
         fwdIdx = head + PTR_W'(i);
         if (CNT_W'(i) < count) begin
            if (qAddr[fwdIdx] == rsReg) fwdA = qData[fwdIdx];
            if (qAddr[fwdIdx] == rtReg) fwdB = qData[fwdIdx];
         end
      end
      if (push && (bus.wb_addr == rsReg)) fwdA = bus.wb_data;
      if (push && (bus.wb_addr == rtReg)) fwdB = bus.wb_data;
      if (rsReg == '0) fwdA = '0;
      if (rtReg == '0) fwdB = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rsReg    <= '0;
         rtReg    <= '0;
         opdValid <= 1'b0;
         opdA     <= '0;
         opdB     <= '0;
      end else begin
         case (state)
            IDLE: begin
               opdValid <= 1'b0;
               if (bus.op_valid) begin
                  rsReg <= bus.op_rs;
                  rtReg <= bus.op_rt;
                  state <= READ;
               end
            end
            READ: begin
               opdA     <= fwdA;
               opdB     <= fwdB;
               opdValid <= 1'b1;
               state    <= RESP;
            end
            RESP: begin
               opdValid <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               opdValid <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   // Queue storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         qAddr[tail] <= bus.wb_addr;
         qData[tail] <= bus.wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         wrDataHold <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop) begin
            head       <= head + PTR_W'(1);
            wrDataHold <= qData[head];
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign bus.op_ready    = opReady;
   assign bus.wb_ready    = wbReady;
   assign bus.opd_valid   = opdValid;
   assign bus.opd_a       = opdA;
   assign bus.opd_b       = opdB;
   assign bus.rf_rd_addr1 = rsReg;
   assign bus.rf_rd_addr2 = rtReg;
   // rf_wr_data keeps the last drained value between writes.
   assign bus.rf_wr_addr  = pop ? qAddr[head] : '0;
   assign bus.rf_wr_data  = pop ? qData[head] : wrDataHold;
   assign bus.wbq_count   = count;
   assign dbgState        = state;
endmodule
